// File: rtl/uart_tx_fifo_if.sv
// Byte push channel into the UART transmitter FIFO.
// Source drives data/valid; the FIFO answers with ready.
interface uart_tx_fifo_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed by a circular byte FIFO.
// Frames are sent LSB-first, back-to-back, at cfg_div clocks per bit.
module uart_tx_fifo #(
  parameter  int FIFO_DEPTH = 16,
  parameter  int DIV_WIDTH  = 16,
  localparam int LW = $clog2(FIFO_DEPTH + 1),
  localparam int AW = $clog2(FIFO_DEPTH)
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 enable,
  input  logic [DIV_WIDTH-1:0] cfg_div,
  uart_tx_fifo_if.slave        in_if,
  output logic                 ser_tx,
  output logic                 busy,
  output logic [LW-1:0]        fifo_level
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  localparam logic [LW-1:0]        FULL  = LW'(FIFO_DEPTH);
  localparam logic [DIV_WIDTH-1:0] DIV_MIN = DIV_WIDTH'(2);

  logic [7:0]           mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wr_q, wr_d;
  logic [AW-1:0]        rd_q, rd_d;
  logic [LW-1:0]        level_q, level_d;
  logic [1:0]           state_q, state_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [2:0]           bit_q, bit_d;
  logic [7:0]           shift_q, shift_d;
  logic                 tx_q, tx_d;

  logic in_ready;
  logic push;
  logic pop;
  logic can_start;
  logic last;

  assign in_ready  = (level_q != FULL);
  assign push      = in_if.in_valid & in_ready;
  assign can_start = enable & (level_q != '0);
  assign last      = (cnt_q == div_q - DIV_WIDTH'(1));

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    unique case (1'b1)
      (state_q == S_IDLE): begin
        if (can_start) begin
          pop = 1'b1;
        end
      end
      (state_q == S_START): begin
        cnt_d = cnt_q + DIV_WIDTH'(1);
        if (last) begin
          cnt_d   = '0;
          tx_d    = shift_q[0];
          state_d = S_DATA;
        end
      end
      (state_q == S_DATA): begin
        cnt_d = cnt_q + DIV_WIDTH'(1);
        if (last) begin
          cnt_d = '0;
          if (bit_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = S_STOP;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
          end
        end
      end
      default: begin
        cnt_d = cnt_q + DIV_WIDTH'(1);
        if (last) begin
          cnt_d   = '0;
          state_d = S_IDLE;
          pop     = can_start;
        end
      end
    endcase
    // Loading a frame also latches the bit period for its whole duration.
    if (pop) begin
      shift_d = mem_q[rd_q];
      div_d   = (cfg_div < DIV_MIN) ? DIV_MIN : cfg_div;
      cnt_d   = '0;
      bit_d   = '0;
      tx_d    = 1'b0;
      state_d = S_START;
    end
  end

  always_comb begin
    wr_d    = push ? wr_q + AW'(1) : wr_q;
    rd_d    = pop  ? rd_q + AW'(1) : rd_q;
    level_d = level_q;
    unique case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_q] <= in_if.in_data;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
      state_q <= S_IDLE;
      div_q   <= '0;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      level_q <= level_d;
      state_q <= state_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  assign in_if.in_ready = in_ready;
  assign ser_tx         = tx_q;
  assign busy           = (state_q != S_IDLE) | (level_q != '0);
  assign fifo_level     = level_q;

endmodule
